// File: rtl/rstack_ctrl.sv
// Return-stack controller for brus16: stack pointer, registered TOS and overflow/underflow policy.
// Define RSTACK_GUARD_EN to reject push-when-full / pop-when-empty and report them via sticky flags.
module rstack_ctrl #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_tos,
    output logic              o_tos_valid,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_err_ovf,
    output logic              o_err_unf,
    input  logic              i_err_clr,
    output logic [DATA_W-1:0] o_ram_di,
    output logic [ADDR_W-1:0] o_ram_wad,
    output logic [ADDR_W-1:0] o_ram_rad,
    output logic              o_ram_wre,
    input  logic [DATA_W-1:0] i_ram_dout
);

    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << ADDR_W) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_tos;
    logic              r_tos_valid;
    logic              r_err_ovf;
    logic              r_err_unf;

    logic              w_push_only;
    logic              w_pop_only;
    logic              w_both;
    logic              w_full;
    logic              w_empty;
    logic              w_push_acc;
    logic              w_pop_acc;
    logic              w_ovf_set;
    logic              w_unf_set;

    logic [ADDR_W-1:0] w_wptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_tos_nxt;
    logic              w_valid_nxt;

    assign w_push_only = i_push & ~i_pop;
    assign w_pop_only  = i_pop & ~i_push;
    assign w_both      = i_push & i_pop;
    assign w_full      = (r_count == CNT_MAX);
    assign w_empty     = (r_count == '0);
    assign w_pop_acc   = w_pop_only & ~w_empty;

`ifdef RSTACK_GUARD_EN
    assign w_push_acc  = w_push_only & ~w_full;
    assign w_ovf_set   = w_push_only & w_full;
    assign w_unf_set   = w_pop_only & w_empty;
`else
    // Push when full is accepted: the RAM write lands on the oldest entry because wptr has wrapped onto it.
    assign w_push_acc  = w_push_only;
    assign w_ovf_set   = 1'b0;
    assign w_unf_set   = 1'b0;
`endif

    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_count_nxt = r_count;
        w_tos_nxt   = r_tos;
        w_valid_nxt = r_tos_valid;
        if (w_both) begin
            // Simultaneous CALL/RET replaces the top entry in place.
            w_tos_nxt   = i_din;
            w_valid_nxt = 1'b1;
            if (w_empty) begin
                w_count_nxt = CNT_ONE;
            end
        end else if (w_push_acc) begin
            w_tos_nxt   = i_din;
            w_valid_nxt = 1'b1;
            if (w_empty) begin
                w_count_nxt = CNT_ONE;
            end else begin
                w_wptr_nxt = r_wptr + PTR_ONE;
                if (!w_full) begin
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
        end else if (w_pop_acc) begin
            if (r_count >= CNT_TWO) begin
                w_tos_nxt   = i_ram_dout;
                w_wptr_nxt  = r_wptr - PTR_ONE;
                w_count_nxt = r_count - CNT_ONE;
            end else begin
                w_tos_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_count_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_count     <= '0;
            r_tos       <= '0;
            r_tos_valid <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_count     <= w_count_nxt;
            r_tos       <= w_tos_nxt;
            r_tos_valid <= w_valid_nxt;
        end
    end

    // A clear in the same cycle as a new fault wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (i_err_clr) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_err_ovf <= 1'b1;
            end
            if (w_unf_set) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    assign o_tos       = r_tos;
    assign o_tos_valid = r_tos_valid;
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_err_ovf   = r_err_ovf;
    assign o_err_unf   = r_err_unf;

    // The old TOS spills into RAM; the entry below TOS sits at wptr-1 for the async read.
    assign o_ram_di    = r_tos;
    assign o_ram_wad   = r_wptr;
    assign o_ram_rad   = r_wptr - PTR_ONE;
    assign o_ram_wre   = w_push_acc & r_tos_valid & rst_n;

endmodule

// File: tb/tb_rstack_ctrl.sv
// Self-checking bench for rstack_ctrl: vector table, hand sequences and randomized ops vs a queue model.
// Build with or without RSTACK_GUARD_EN, matching the RTL build.
module tb_rstack_ctrl;

    localparam int DW  = 13;
    localparam int AW  = 4;
    localparam int CAP = (1 << AW) + 1;
`ifdef RSTACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk;
    logic          rstN;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [DW-1:0] tos;
    logic          tosValid;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          errOvf;
    logic          errUnf;
    logic          errClr;
    logic [DW-1:0] ramDi;
    logic [AW-1:0] ramWad;
    logic [AW-1:0] ramRad;
    logic          ramWre;
    logic [DW-1:0] ramDout;

    logic [DW-1:0] ramMem [1 << AW];

    logic [DW-1:0] mq[$];
    bit            mOvf;
    bit            mUnf;

    int nChecks;
    int nFails;

    rstack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .i_push     (push),
        .i_pop      (pop),
        .i_din      (din),
        .o_tos      (tos),
        .o_tos_valid(tosValid),
        .o_count    (count),
        .o_full     (full),
        .o_empty    (empty),
        .o_err_ovf  (errOvf),
        .o_err_unf  (errUnf),
        .i_err_clr  (errClr),
        .o_ram_di   (ramDi),
        .o_ram_wad  (ramWad),
        .o_ram_rad  (ramRad),
        .o_ram_wre  (ramWre),
        .i_ram_dout (ramDout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM16SDP: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (ramWre) begin
            ramMem[ramWad] <= ramDi;
        end
    end
    assign ramDout = ramMem[ramRad];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack-level reference: the queue holds every live entry, TOS at the back.
    task automatic modelStep(input bit p, input bit q, input logic [DW-1:0] d, input bit c);
        bit setO;
        bit setU;
        setO = 1'b0;
        setU = 1'b0;
        if (p && q) begin
            if (mq.size() == 0) mq.push_back(d);
            else mq[mq.size()-1] = d;
        end else if (p) begin
            if (mq.size() < CAP) mq.push_back(d);
            else if (GUARD) setO = 1'b1;
            else begin
                mq.delete(0);
                mq.push_back(d);
            end
        end else if (q) begin
            if (mq.size() > 0) mq.delete(mq.size()-1);
            else if (GUARD) setU = 1'b1;
        end
        if (c) begin
            mOvf = 1'b0;
            mUnf = 1'b0;
        end else begin
            if (setO) mOvf = 1'b1;
            if (setU) mUnf = 1'b1;
        end
    endtask

    task automatic checkState();
        checkOutput("tos", 32'(tos), (mq.size() > 0) ? 32'(mq[mq.size()-1]) : 32'd0);
        checkOutput("tos_valid", 32'(tosValid), 32'(mq.size() > 0));
        checkOutput("count", 32'(count), 32'(mq.size()));
        checkOutput("full", 32'(full), 32'(mq.size() == CAP));
        checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
        checkOutput("err_ovf", 32'(errOvf), 32'(mOvf));
        checkOutput("err_unf", 32'(errUnf), 32'(mUnf));
    endtask

    task automatic applyStimulus(input bit p, input bit q, input logic [DW-1:0] d, input bit c,
                                 output logic sWre, output logic [AW-1:0] sWad, output logic [DW-1:0] sDi);
        bit expWre;
        @(negedge clk);
        push   = p;
        pop    = q;
        din    = d;
        errClr = c;
        #1;
        sWre = ramWre;
        sWad = ramWad;
        sDi  = ramDi;
        expWre = p && !q && (mq.size() > 0) && ((mq.size() < CAP) || !GUARD);
        checkOutput("ram_wre", 32'(ramWre), 32'(expWre));
        if (expWre) checkOutput("ram_di", 32'(ramDi), 32'(mq[mq.size()-1]));
        modelStep(p, q, d, c);
        @(posedge clk);
        #1;
        checkState();
    endtask

    task automatic doReset();
        push   = 1'b0;
        pop    = 1'b0;
        din    = '0;
        errClr = 1'b0;
        rstN   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        mq.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
    endtask

    typedef struct {
        bit            push;
        bit            pop;
        logic [DW-1:0] din;
        bit            wre;
        logic [AW-1:0] wad;
        logic [DW-1:0] tos;
        bit            valid;
        logic [AW:0]   count;
    } vec_t;

    initial begin
        vec_t          vecs[8];
        logic          sWre;
        logic [AW-1:0] sWad;
        logic [DW-1:0] sDi;
        int            mode;

        nChecks = 0;
        nFails  = 0;

        vecs[0] = '{1'b1, 1'b0, 13'h0001, 1'b0, 4'd0, 13'h0001, 1'b1, 5'd1};
        vecs[1] = '{1'b1, 1'b0, 13'h0002, 1'b1, 4'd0, 13'h0002, 1'b1, 5'd2};
        vecs[2] = '{1'b1, 1'b0, 13'h0003, 1'b1, 4'd1, 13'h0003, 1'b1, 5'd3};
        vecs[3] = '{1'b0, 1'b1, 13'h0000, 1'b0, 4'd0, 13'h0002, 1'b1, 5'd2};
        vecs[4] = '{1'b0, 1'b1, 13'h0000, 1'b0, 4'd0, 13'h0001, 1'b1, 5'd1};
        vecs[5] = '{1'b0, 1'b1, 13'h0000, 1'b0, 4'd0, 13'h0000, 1'b0, 5'd0};
        vecs[6] = '{1'b1, 1'b1, 13'h0042, 1'b0, 4'd0, 13'h0042, 1'b1, 5'd1};
        vecs[7] = '{1'b0, 1'b1, 13'h0000, 1'b0, 4'd0, 13'h0000, 1'b0, 5'd0};

        doReset();
        #1;
        checkState();

        // Test 1: pop on empty, then pop with a simultaneous clear.
        applyStimulus(1'b0, 1'b1, 13'h0, 1'b0, sWre, sWad, sDi);
        checkOutput("t1_err_unf", 32'(errUnf), 32'(GUARD));
        checkOutput("t1_tos", 32'(tos), 32'd0);
        applyStimulus(1'b0, 1'b1, 13'h0, 1'b1, sWre, sWad, sDi);
        checkOutput("t1_clr_priority", 32'(errUnf), 32'd0);

        // Tests 2 and 5 from the vector table.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].din, 1'b0, sWre, sWad, sDi);
            checkOutput($sformatf("vec%0d_wre", i), 32'(sWre), 32'(vecs[i].wre));
            if (vecs[i].wre) checkOutput($sformatf("vec%0d_wad", i), 32'(sWad), 32'(vecs[i].wad));
            checkOutput($sformatf("vec%0d_tos", i), 32'(tos), 32'(vecs[i].tos));
            checkOutput($sformatf("vec%0d_valid", i), 32'(tosValid), 32'(vecs[i].valid));
            checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].count));
        end

        // Test 3: fill to capacity, push once more, clear, drain.
        doReset();
        for (int i = 0; i < CAP; i++) begin
            applyStimulus(1'b1, 1'b0, DW'(13'h100 + i), 1'b0, sWre, sWad, sDi);
        end
        checkOutput("t3_full", 32'(full), 32'd1);
        checkOutput("t3_tos", 32'(tos), 32'h110);
        applyStimulus(1'b1, 1'b0, 13'h111, 1'b0, sWre, sWad, sDi);
        checkOutput("t3_ovf_wre", 32'(sWre), GUARD ? 32'd0 : 32'd1);
        checkOutput("t3_ovf_tos", 32'(tos), GUARD ? 32'h110 : 32'h111);
        checkOutput("t3_err_ovf", 32'(errOvf), 32'(GUARD));
        checkOutput("t3_count_sat", 32'(count), 32'(CAP));
        applyStimulus(1'b0, 1'b0, 13'h0, 1'b1, sWre, sWad, sDi);
        checkOutput("t3_err_clr", 32'(errOvf), 32'd0);
        for (int k = 1; k <= CAP; k++) begin
            applyStimulus(1'b0, 1'b1, 13'h0, 1'b0, sWre, sWad, sDi);
            checkOutput($sformatf("t3_pop%0d", k), 32'(tos),
                        (k == CAP) ? 32'd0 : ((GUARD ? 32'h110 : 32'h111) - 32'(k)));
        end
        checkOutput("t3_empty", 32'(empty), 32'd1);

        // Test 4: push+pop with five live entries.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, DW'(13'h10 + i), 1'b0, sWre, sWad, sDi);
        end
        applyStimulus(1'b1, 1'b1, 13'h1ABC, 1'b0, sWre, sWad, sDi);
        checkOutput("t4_wre", 32'(sWre), 32'd0);
        checkOutput("t4_tos", 32'(tos), 32'h1ABC);
        checkOutput("t4_count", 32'(count), 32'd5);
        checkOutput("t4_errs", 32'({errOvf, errUnf}), 32'd0);
        applyStimulus(1'b0, 1'b1, 13'h0, 1'b0, sWre, sWad, sDi);
        checkOutput("t4_pop_tos", 32'(tos), 32'h13);

        // Test 6: asynchronous reset mid-cycle with push held.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, DW'(13'h20 + i), 1'b0, sWre, sWad, sDi);
        end
        @(negedge clk);
        push = 1'b1;
        din  = 13'h0777;
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("t6_count", 32'(count), 32'd0);
        checkOutput("t6_tos", 32'(tos), 32'd0);
        checkOutput("t6_valid", 32'(tosValid), 32'd0);
        checkOutput("t6_wre", 32'(ramWre), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t6_wre_held", 32'(ramWre), 32'd0);
        push = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        mq.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
        applyStimulus(1'b1, 1'b0, 13'h0AAA, 1'b0, sWre, sWad, sDi);
        applyStimulus(1'b1, 1'b0, 13'h0BBB, 1'b0, sWre, sWad, sDi);
        checkOutput("t6_wad", 32'(sWad), 32'd0);
        checkOutput("t6_di", 32'(sDi), 32'h0AAA);

        // Randomized traffic alternating push-heavy and pop-heavy phases.
        doReset();
        mode = 0;
        for (int n = 0; n < 800; n++) begin
            int  r;
            bit  p;
            bit  q;
            if ((n % 60) == 0) mode = 1 - mode;
            r = int'($urandom_range(0, 99));
            if (mode == 1) begin
                p = (r < 80);
                q = (r >= 70);
            end else begin
                p = (r < 25);
                q = (r >= 15);
            end
            applyStimulus(p, q, DW'($urandom_range(0, (1 << DW) - 1)),
                          ($urandom_range(0, 19) == 0), sWre, sWad, sDi);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
